// File: rtl/can_pkg.sv
// Shared CAN definitions for the receive path: stuffing rule constants and
// the destuffer state encoding, which the frame decoder also uses.
package can_pkg;

   // Length of an equal-bit run after which a complementary stuff bit must follow
   localparam int CAN_STUFF_LEN = 5;

   // Bus level of a dominant bit
   localparam logic CAN_DOMINANT = 1'b0;

   // Destuffer states (plain constants so legacy decoders can compare against them)
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_EXPECT = 2'd2;
   localparam logic [1:0] ST_ERROR  = 2'd3;

   // Run length after accepting bit b, given the previous bit and run length
   function automatic logic [2:0] can_run_next(input logic b, input logic last,
                                               input logic [2:0] run);
      return (b == last) ? run + 3'd1 : 3'd1;
   endfunction

endpackage

// File: rtl/can_bit_destuff.sv
// CAN receive bit destuffer: removes stuff bits from SOF through the CRC
// field, flags stuff errors and counts removed stuff bits.
module can_bit_destuff
   import can_pkg::*;
#(
   parameter int STUFF_LEN = CAN_STUFF_LEN,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_en,
   input  logic             rx_bit,
   input  logic             stuff_en,
   input  logic             err_clr,
   output logic             dout,
   output logic             dout_valid,
   output logic             stuff_bit,
   output logic             stuff_err,
   output logic [CNT_W-1:0] stuff_cnt
);

   localparam logic [2:0] RUN_MAX = 3'(STUFF_LEN);

   logic [1:0]       state_q, state_d;
   logic [2:0]       run_len_q, run_len_d;
   logic             last_bit_q, last_bit_d;
   logic             dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             stuff_bit_q, stuff_bit_d;
   logic             stuff_err_q, stuff_err_d;
   logic [CNT_W-1:0] stuff_cnt_q, stuff_cnt_d;
   logic [2:0]       run_nxt;

   assign run_nxt = can_run_next(rx_bit, last_bit_q, run_len_q);

   // Next-state logic: everything advances only on sample strobes, except the
   // error clear, which must not be lost when it arrives between sample points.
   always_comb begin
      state_d      = state_q;
      run_len_d    = run_len_q;
      last_bit_d   = last_bit_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      stuff_bit_d  = 1'b0;
      stuff_err_d  = stuff_err_q & ~err_clr;
      stuff_cnt_d  = stuff_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (sample_en) begin
               dout_d       = rx_bit;
               dout_valid_d = 1'b1;
               if (stuff_en) begin
                  // SOF opens a new run
                  last_bit_d = rx_bit;
                  run_len_d  = 3'd1;
                  state_d    = (RUN_MAX == 3'd1) ? ST_EXPECT : ST_RUN;
               end
            end
         end

         ST_RUN: begin
            if (sample_en) begin
               dout_d       = rx_bit;
               dout_valid_d = 1'b1;
               if (!stuff_en) begin
                  run_len_d = 3'd0;
                  state_d   = ST_IDLE;
               end else begin
                  last_bit_d = rx_bit;
                  run_len_d  = run_nxt;
                  if (run_nxt == RUN_MAX) state_d = ST_EXPECT;
               end
            end
         end

         ST_EXPECT: begin
            if (sample_en) begin
               if (!stuff_en) begin
                  // Stuffing region ended; the pending stuff bit is not owed
                  dout_d       = rx_bit;
                  dout_valid_d = 1'b1;
                  run_len_d    = 3'd0;
                  state_d      = ST_IDLE;
               end else if (rx_bit != last_bit_q) begin
                  // Stuff bit: drop it, but it seeds the next run
                  stuff_bit_d = 1'b1;
                  if (stuff_cnt_q != '1) stuff_cnt_d = stuff_cnt_q + 1'b1;
                  last_bit_d  = rx_bit;
                  run_len_d   = 3'd1;
                  state_d     = ST_RUN;
               end else begin
                  // A new error overrides a simultaneous clear
                  stuff_err_d = 1'b1;
                  state_d     = ST_ERROR;
               end
            end
         end

         default: begin
            if (err_clr || (sample_en && !stuff_en)) begin
               run_len_d = 3'd0;
               state_d   = ST_IDLE;
            end
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         run_len_q    <= 3'd0;
         last_bit_q   <= 1'b1;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         stuff_bit_q  <= 1'b0;
         stuff_err_q  <= 1'b0;
         stuff_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         run_len_q    <= run_len_d;
         last_bit_q   <= last_bit_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         stuff_bit_q  <= stuff_bit_d;
         stuff_err_q  <= stuff_err_d;
         stuff_cnt_q  <= stuff_cnt_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign stuff_bit  = stuff_bit_q;
   assign stuff_err  = stuff_err_q;
   assign stuff_cnt  = stuff_cnt_q;

endmodule

// File: tb/tb_can_bit_destuff.sv
// Directed bench for the CAN bit destuffer.
module tb_can_bit_destuff;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_en = 1'b0;
   logic       rx_bit = 1'b0;
   logic       stuff_en = 1'b0;
   logic       err_clr = 1'b0;
   logic       dout, dout_valid, stuff_bit, stuff_err;
   logic [7:0] stuff_cnt;

   int total = 0;
   int bad = 0;
   int n_valid, n_sbit;
   logic dq[$];

   can_bit_destuff #(.STUFF_LEN(5), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .rx_bit(rx_bit),
      .stuff_en(stuff_en), .err_clr(err_clr), .dout(dout),
      .dout_valid(dout_valid), .stuff_bit(stuff_bit), .stuff_err(stuff_err),
      .stuff_cnt(stuff_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One sample cycle; outputs observed on the following falling edge
   task automatic send(input logic b, input logic se, input logic clr = 1'b0);
      @(negedge clk);
      sample_en = 1'b1; rx_bit = b; stuff_en = se; err_clr = clr;
      @(negedge clk);
      sample_en = 1'b0; err_clr = 1'b0;
      if (dout_valid) begin n_valid++; dq.push_back(dout); end
      if (stuff_bit) n_sbit++;
   endtask

   task automatic clear_pulse();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; sample_en = 1'b0; stuff_en = 1'b0; err_clr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      n_valid = 0; n_sbit = 0; dq.delete();
   endtask

   task automatic clr_cnt();
      n_valid = 0; n_sbit = 0; dq.delete();
   endtask

   initial begin
      logic [6:0]  v1;
      logic [10:0] v5;
      logic        v;
      int          zeros;

      // Reset state
      do_reset();
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_sbit", stuff_bit, 0);
      chk("rst_err", stuff_err, 0);
      chk("rst_cnt", stuff_cnt, 0);

      // 1: 0,0,0,0,0,1(stuff),0
      v1 = 7'b0100000;
      for (int i = 0; i < 7; i++) begin
         send(v1[i], 1'b1);
         if (i == 5) chk("t1_sbit_strobe", stuff_bit, 1);
      end
      chk("t1_valids", n_valid, 6);
      zeros = 0;
      foreach (dq[i]) if (dq[i] == 1'b0) zeros++;
      chk("t1_all_zero", zeros, 6);
      chk("t1_cnt", stuff_cnt, 1);
      chk("t1_err", stuff_err, 0);

      // 2: six 1s -> stuff error
      do_reset();
      for (int i = 0; i < 6; i++) send(1'b1, 1'b1);
      chk("t2_valids", n_valid, 5);
      chk("t2_err", stuff_err, 1);
      clr_cnt();
      send(1'b0, 1'b1); send(1'b1, 1'b1);
      chk("t2_err_novalid", n_valid, 0);
      chk("t2_err_sticky", stuff_err, 1);
      clear_pulse();
      chk("t2_err_cleared", stuff_err, 0);
      // back in IDLE: next stuff_en bit is a SOF and passes
      send(1'b0, 1'b1);
      chk("t2_idle_sof", n_valid, 1);
      chk("t2_cnt", stuff_cnt, 0);

      // 3: 20 alternating bits
      do_reset();
      for (int i = 0; i < 20; i++) send(1'(i & 1), 1'b1);
      chk("t3_valids", n_valid, 20);
      chk("t3_sbits", n_sbit, 0);
      for (int i = 0; i < 20 && i < dq.size(); i++)
         chk($sformatf("t3_dout%0d", i), dq[i], i & 1);

      // 4: stuff_en=0, eight 1s
      do_reset();
      for (int i = 0; i < 8; i++) send(1'b1, 1'b0);
      chk("t4_valids", n_valid, 8);
      zeros = 0;
      foreach (dq[i]) if (dq[i] == 1'b1) zeros++;
      chk("t4_all_one", zeros, 8);
      chk("t4_sbits", n_sbit, 0);
      chk("t4_err", stuff_err, 0);

      // 5: stuff bit starts the next run
      do_reset();
      v5 = 11'b01111100000;
      for (int i = 0; i < 11; i++) send(v5[i], 1'b1);
      chk("t5_valids", n_valid, 9);
      chk("t5_sbits", n_sbit, 2);
      chk("t5_cnt", stuff_cnt, 2);
      chk("t5_err", stuff_err, 0);

      // 6: reset mid-frame discards history
      do_reset();
      for (int i = 0; i < 4; i++) send(1'b0, 1'b1);
      do_reset();
      chk("t6_post_rst_dout", dout, 0);
      chk("t6_post_rst_valid", dout_valid, 0);
      chk("t6_post_rst_err", stuff_err, 0);
      send(1'b0, 1'b1); send(1'b0, 1'b1);
      // a third 0 would be bit 3 of a fresh run, no stuff owed yet
      send(1'b0, 1'b1);
      chk("t6_valids", n_valid, 3);
      chk("t6_sbits", n_sbit, 0);
      chk("t6_err", stuff_err, 0);

      // stuff_en falls while a stuff bit is pending: pass-through, no error
      do_reset();
      for (int i = 0; i < 5; i++) send(1'b1, 1'b1);
      clr_cnt();
      send(1'b1, 1'b0);
      chk("fall_pass_valid", n_valid, 1);
      chk("fall_pass_dout", (dq.size() > 0) ? dq[0] : 2, 1);
      chk("fall_err", stuff_err, 0);

      // err_clr coinciding with a new error: error wins
      do_reset();
      for (int i = 0; i < 5; i++) send(1'b0, 1'b1);
      send(1'b0, 1'b1, 1'b1);
      chk("clr_vs_err", stuff_err, 1);
      // ERROR left via stuff_en=0 sample: no output, flag stays
      clr_cnt();
      send(1'b1, 1'b0);
      chk("err_exit_novalid", n_valid, 0);
      chk("err_exit_sticky", stuff_err, 1);
      send(1'b1, 1'b0);
      chk("err_exit_pass", n_valid, 1);

      // stats counter saturates at all-ones
      do_reset();
      for (int i = 0; i < 5; i++) send(1'b0, 1'b1);
      v = 1'b0;
      for (int k = 0; k < 260; k++) begin
         v = ~v;
         for (int i = 0; i < 5; i++) send(v, 1'b1);
      end
      chk("sat_cnt", stuff_cnt, 255);
      chk("sat_sbits", n_sbit, 260);
      chk("sat_err", stuff_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
